// File: rtl/coin_scheduler_pkg.sv
// Shared game constants for the coin scheduler and the coin draw logic.
// Holds playfield geometry, motion/spawn timing and the scheduler state encodings.
package coin_scheduler_pkg;

  localparam int unsigned COIN_WIDTH   = 20;
  localparam int unsigned COIN_HEIGHT  = 20;
  localparam int unsigned SPAWN_X      = 620;
  localparam int unsigned STEP         = 2;
  localparam int unsigned SPAWN_PERIOD = 160;
  localparam int unsigned Y_BASE       = 40;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Coin counter add that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/coin_scheduler_if.sv
// Control, bird box and coin outputs of the coin scheduler, bundled for one port.
// The game side drives through master; the scheduler sits on slave.
interface coin_scheduler_if;

  logic       Start;
  logic       Ack;
  logic       Tick;
  logic       Game_Over;
  logic [7:0] Rand;
  logic [9:0] Bird_X_L;
  logic [9:0] Bird_X_R;
  logic [9:0] Bird_Y_T;
  logic [9:0] Bird_Y_B;

  logic [9:0] Coin0_X_L;
  logic [9:0] Coin1_X_L;
  logic [9:0] Coin0_Y_T;
  logic [9:0] Coin1_Y_T;
  logic       Coin0_Valid;
  logic       Coin1_Valid;
  logic [7:0] Coin_Count;
  logic       Coin_Get;
  logic       q_Idle;
  logic       q_Run;
  logic       q_Done;

  modport master (
    output Start, Ack, Tick, Game_Over, Rand, Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B,
    input  Coin0_X_L, Coin1_X_L, Coin0_Y_T, Coin1_Y_T, Coin0_Valid, Coin1_Valid,
           Coin_Count, Coin_Get, q_Idle, q_Run, q_Done
  );

  modport slave (
    input  Start, Ack, Tick, Game_Over, Rand, Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B,
    output Coin0_X_L, Coin1_X_L, Coin0_Y_T, Coin1_Y_T, Coin0_Valid, Coin1_Valid,
           Coin_Count, Coin_Get, q_Idle, q_Run, q_Done
  );

endinterface

// File: rtl/coin_slot.sv
// One coin slot: position and live flag with load/clear/move controls,
// plus the bird overlap test on the current (pre-update) values.
module coin_slot #(
  parameter int unsigned COIN_WIDTH  = coin_scheduler_pkg::COIN_WIDTH,
  parameter int unsigned COIN_HEIGHT = coin_scheduler_pkg::COIN_HEIGHT,
  parameter int unsigned SPAWN_X     = coin_scheduler_pkg::SPAWN_X,
  parameter int unsigned STEP        = coin_scheduler_pkg::STEP,
  parameter int unsigned Y_BASE      = coin_scheduler_pkg::Y_BASE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] rand_val,
  input  logic       clear,
  input  logic       move,
  input  logic [9:0] bird_x_l,
  input  logic [9:0] bird_x_r,
  input  logic [9:0] bird_y_t,
  input  logic [9:0] bird_y_b,
  output logic [9:0] x_l,
  output logic [9:0] y_t,
  output logic       valid,
  output logic       overlap,
  output logic       below_step
);

  localparam logic [10:0] WidthV  = 11'(COIN_WIDTH);
  localparam logic [10:0] HeightV = 11'(COIN_HEIGHT);
  localparam logic [9:0]  StepV   = 10'(STEP);
  localparam logic [9:0]  SpawnXV = 10'(SPAWN_X);
  localparam logic [9:0]  YBaseV  = 10'(Y_BASE);

  logic [9:0]  x_l_q, y_t_q;
  logic        valid_q;
  logic [10:0] x_r_edge, y_b_edge;

  // Far edges are formed in 11 bits so a coin near 1023 cannot wrap.
  assign x_r_edge = {1'b0, x_l_q} + WidthV;
  assign y_b_edge = {1'b0, y_t_q} + HeightV;

  assign overlap = valid_q
                && (bird_x_r > x_l_q)
                && ({1'b0, bird_x_l} < x_r_edge)
                && (bird_y_b > y_t_q)
                && ({1'b0, bird_y_t} < y_b_edge);

  assign below_step = x_l_q < StepV;

  // A load wins over clear so a slot freed this cycle can take the new coin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_l_q   <= '0;
      y_t_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      x_l_q   <= SpawnXV;
      y_t_q   <= YBaseV + {2'b00, rand_val};
      valid_q <= 1'b1;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (move) begin
      x_l_q <= x_l_q - StepV;
    end
  end

  assign x_l   = x_l_q;
  assign y_t   = y_t_q;
  assign valid = valid_q;

endmodule

// File: rtl/coin_scheduler.sv
// Coin scheduler: spawns coins into two slots, scrolls them left per Tick,
// detects bird pickups and counts them over a game (IDLE/RUN/DONE).
module coin_scheduler #(
  parameter int unsigned COIN_WIDTH   = coin_scheduler_pkg::COIN_WIDTH,
  parameter int unsigned COIN_HEIGHT  = coin_scheduler_pkg::COIN_HEIGHT,
  parameter int unsigned SPAWN_X      = coin_scheduler_pkg::SPAWN_X,
  parameter int unsigned STEP         = coin_scheduler_pkg::STEP,
  parameter int unsigned SPAWN_PERIOD = coin_scheduler_pkg::SPAWN_PERIOD,
  parameter int unsigned Y_BASE       = coin_scheduler_pkg::Y_BASE
) (
  input logic             Clk,
  input logic             reset,
  coin_scheduler_if.slave bus
);

  import coin_scheduler_pkg::*;

  localparam int unsigned       TimerW    = $clog2(SPAWN_PERIOD);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(SPAWN_PERIOD - 1);

  logic [1:0]        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [7:0]        count_q, count_d;
  logic              get_q, get_d;

  logic       run, start_go, tick_run, spawn;
  logic [1:0] valid, overlap, below, hit, tick_clr, live, move, clear, load;
  logic [9:0] x_l [2];
  logic [9:0] y_t [2];

  assign run      = (state_q == ST_RUN);
  assign start_go = (state_q == ST_IDLE) && bus.Start;
  assign tick_run = run && bus.Tick;
  assign spawn    = tick_run && (timer_q == TimerLast);

  // Collection beats motion; a coin already under STEP is retired instead of moved.
  assign hit      = overlap & {2{run}};
  assign tick_clr = {2{tick_run}} & valid & ~hit & below;
  assign move     = {2{tick_run}} & valid & ~hit & ~below;
  assign live     = valid & ~hit & ~tick_clr;
  assign clear    = hit | tick_clr | {2{start_go}};

  // Spawn goes to the lowest slot still free after this cycle's clears.
  assign load[0] = spawn & ~live[0];
  assign load[1] = spawn & live[0] & ~live[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.Start)     state_d = ST_RUN;
      ST_RUN:  if (bus.Game_Over) state_d = ST_DONE;
      ST_DONE: if (bus.Ack)       state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (start_go) begin
      timer_d = '0;
    end else if (tick_run) begin
      timer_d = (timer_q == TimerLast) ? '0 : timer_q + TimerW'(1);
    end
  end

  assign count_d = start_go ? 8'd0 : sat_add(count_q, {1'b0, hit[0]} + {1'b0, hit[1]});
  assign get_d   = |hit;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      count_q <= '0;
      get_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      get_q   <= get_d;
    end
  end

  coin_slot #(
    .COIN_WIDTH  (COIN_WIDTH),
    .COIN_HEIGHT (COIN_HEIGHT),
    .SPAWN_X     (SPAWN_X),
    .STEP        (STEP),
    .Y_BASE      (Y_BASE)
  ) u_slot0 (
    .clk        (Clk),
    .rst_n      (reset),
    .load       (load[0]),
    .rand_val   (bus.Rand),
    .clear      (clear[0]),
    .move       (move[0]),
    .bird_x_l   (bus.Bird_X_L),
    .bird_x_r   (bus.Bird_X_R),
    .bird_y_t   (bus.Bird_Y_T),
    .bird_y_b   (bus.Bird_Y_B),
    .x_l        (x_l[0]),
    .y_t        (y_t[0]),
    .valid      (valid[0]),
    .overlap    (overlap[0]),
    .below_step (below[0])
  );

  coin_slot #(
    .COIN_WIDTH  (COIN_WIDTH),
    .COIN_HEIGHT (COIN_HEIGHT),
    .SPAWN_X     (SPAWN_X),
    .STEP        (STEP),
    .Y_BASE      (Y_BASE)
  ) u_slot1 (
    .clk        (Clk),
    .rst_n      (reset),
    .load       (load[1]),
    .rand_val   (bus.Rand),
    .clear      (clear[1]),
    .move       (move[1]),
    .bird_x_l   (bus.Bird_X_L),
    .bird_x_r   (bus.Bird_X_R),
    .bird_y_t   (bus.Bird_Y_T),
    .bird_y_b   (bus.Bird_Y_B),
    .x_l        (x_l[1]),
    .y_t        (y_t[1]),
    .valid      (valid[1]),
    .overlap    (overlap[1]),
    .below_step (below[1])
  );

  assign bus.Coin0_X_L   = x_l[0];
  assign bus.Coin1_X_L   = x_l[1];
  assign bus.Coin0_Y_T   = y_t[0];
  assign bus.Coin1_Y_T   = y_t[1];
  assign bus.Coin0_Valid = valid[0];
  assign bus.Coin1_Valid = valid[1];
  assign bus.Coin_Count  = count_q;
  assign bus.Coin_Get    = get_q;
  assign bus.q_Idle      = (state_q == ST_IDLE);
  assign bus.q_Run       = run;
  assign bus.q_Done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_coin_scheduler.sv
// Scoreboard bench for coin_scheduler: a game-level model predicts every cycle's
// outputs into a queue, and a monitor pops and compares just after each rising edge.
module tb_coin_scheduler;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coin_scheduler_if bus ();

  coin_scheduler dut (
    .Clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       q_idle, q_run, q_done, v0, v1;
    logic [9:0] x0, y0, x1, y1;
    logic [7:0] cnt;
    logic       get;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Game-level model: 0 idle, 1 run, 2 done; coins as plain integers.
  int m_state, m_cnt, m_timer;
  bit m_get;
  bit m_v[2];
  int m_x[2];
  int m_y[2];

  function automatic obs_t dut_obs();
    obs_t o;
    o.q_idle = bus.q_Idle;      o.q_run = bus.q_Run;        o.q_done = bus.q_Done;
    o.v0     = bus.Coin0_Valid; o.v1    = bus.Coin1_Valid;
    o.x0     = bus.Coin0_X_L;   o.y0    = bus.Coin0_Y_T;
    o.x1     = bus.Coin1_X_L;   o.y1    = bus.Coin1_Y_T;
    o.cnt    = bus.Coin_Count;  o.get   = bus.Coin_Get;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.q_idle = (m_state == 0); o.q_run = (m_state == 1); o.q_done = (m_state == 2);
    o.v0  = m_v[0];        o.v1 = m_v[1];
    o.x0  = 10'(m_x[0]);   o.y0 = 10'(m_y[0]);
    o.x1  = 10'(m_x[1]);   o.y1 = 10'(m_y[1]);
    o.cnt = 8'(m_cnt);     o.get = m_get;
    return o;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_timer = 0; m_get = 0;
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
  endtask

  task automatic check(string name, obs_t got, obs_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got i/r/d=%b%b%b v=%b%b c0=(%0d,%0d) c1=(%0d,%0d) cnt=%0d get=%b; want i/r/d=%b%b%b v=%b%b c0=(%0d,%0d) c1=(%0d,%0d) cnt=%0d get=%b",
                  name, got.q_idle, got.q_run, got.q_done, got.v0, got.v1, got.x0, got.y0,
                  got.x1, got.y1, got.cnt, got.get, want.q_idle, want.q_run, want.q_done,
                  want.v0, want.v1, want.x0, want.y0, want.x1, want.y1, want.cnt, want.get);
  endtask

  // One clock of game rules applied to the inputs currently on the bus.
  task automatic model_step();
    bit hit[2];
    int n;
    case (m_state)
      0: begin
        m_get = 0;
        if (bus.Start) begin
          m_state = 1; m_cnt = 0; m_timer = 0; m_v[0] = 0; m_v[1] = 0;
        end
      end
      1: begin
        n = 0;
        for (int i = 0; i < 2; i++) begin
          hit[i] = m_v[i] && (bus.Bird_X_R > m_x[i]) && (bus.Bird_X_L < m_x[i] + 20)
                          && (bus.Bird_Y_B > m_y[i]) && (bus.Bird_Y_T < m_y[i] + 20);
          if (hit[i]) n++;
        end
        m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
        m_get = (n > 0);
        for (int i = 0; i < 2; i++) begin
          if (hit[i]) m_v[i] = 0;
          else if (m_v[i] && bus.Tick) begin
            if (m_x[i] < 2) m_v[i] = 0;
            else m_x[i] = m_x[i] - 2;
          end
        end
        if (bus.Tick) begin
          if (m_timer == 159) begin
            m_timer = 0;
            if (!m_v[0]) begin
              m_v[0] = 1; m_x[0] = 620; m_y[0] = 40 + int'(bus.Rand);
            end else if (!m_v[1]) begin
              m_v[1] = 1; m_x[1] = 620; m_y[1] = 40 + int'(bus.Rand);
            end
          end else begin
            m_timer++;
          end
        end
        if (bus.Game_Over) m_state = 2;
      end
      default: begin
        m_get = 0;
        if (bus.Ack) m_state = 0;
      end
    endcase
  endtask

  task automatic cycle();
    model_step();
    exp_q.push_back(model_obs());
    @(negedge clk);
  endtask

  task automatic set_bird(int xl, int xr, int yt, int yb);
    bus.Bird_X_L = 10'(xl); bus.Bird_X_R = 10'(xr);
    bus.Bird_Y_T = 10'(yt); bus.Bird_Y_B = 10'(yb);
  endtask

  task automatic bird_far();
    set_bird(0, 5, 0, 10);
  endtask

  task automatic random_cycle();
    int xl, yt;
    xl = int'($urandom_range(0, 640));
    yt = int'($urandom_range(20, 300));
    set_bird(xl, xl + int'($urandom_range(1, 40)), yt, yt + int'($urandom_range(1, 40)));
    bus.Tick      = ($urandom_range(0, 1) == 1);
    bus.Rand      = 8'($urandom);
    bus.Start     = ($urandom_range(0, 7) == 0);
    bus.Ack       = ($urandom_range(0, 7) == 0);
    bus.Game_Over = ($urandom_range(0, 599) == 0);
    cycle();
  endtask

  task automatic enter_run();
    bus.Game_Over = 1'b0;
    for (int k = 0; k < 4 && m_state != 1; k++) begin
      bus.Start = 1'b1; bus.Ack = 1'b1;
      cycle();
    end
    bus.Start = 1'b0; bus.Ack = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      obs_t w;
      w = exp_q.pop_front();
      check($sformatf("cycle@%0t", $time), dut_obs(), w);
    end
  end

  initial begin
    bus.Start = 0; bus.Ack = 0; bus.Tick = 0; bus.Game_Over = 0; bus.Rand = 0;
    bird_far();
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_values", dut_obs(), model_obs());
    rst_n = 1'b1;
    cycle();

    // First spawn after 160 Ticks, scroll to x=310, edge touch, then a real pickup.
    bus.Rand = 8'd70; bus.Start = 1'b1;
    cycle();
    bus.Start = 1'b0; bus.Tick = 1'b1;
    repeat (160) cycle();
    repeat (155) cycle();
    bus.Tick = 1'b0;
    set_bird(290, 310, 100, 120);
    cycle();
    set_bird(300, 320, 100, 120);
    cycle();
    bird_far();
    repeat (3) cycle();

    repeat (3000) random_cycle();

    // Asynchronous reset in the middle of a game.
    enter_run();
    repeat (50) random_cycle();
    enter_run();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", dut_obs(), model_obs());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.Start = 0; bus.Ack = 0; bus.Game_Over = 0; bus.Tick = 1; bird_far();
    repeat (2) cycle();

    // Double pickups until the counter saturates, then one more to hold at 255.
    enter_run();
    bus.Tick = 1'b1;
    for (int r = 0; r < 129; r++) begin
      int k;
      k = 0;
      bird_far();
      bus.Tick = 1'b1;
      while (!(m_v[0] && m_v[1]) && k < 400) begin
        bus.Rand = 8'($urandom);
        cycle();
        k++;
      end
      if (k >= 400) begin
        n_checks++;
        $display("FAIL double_wait round %0d: got no two live coins within %0d cycles, required both", r, k);
      end
      bus.Tick = 1'b0;
      set_bird(0, 1023, 0, 1023);
      cycle();
    end
    bird_far();

    // Game over freezes coins; Ack returns to idle; Start clears the count.
    bus.Tick = 1'b1;
    repeat (200) cycle();
    bus.Game_Over = 1'b1;
    cycle();
    bus.Game_Over = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.Tick = ($urandom_range(0, 1) == 1);
      cycle();
    end
    bus.Ack = 1'b1;
    cycle();
    bus.Ack = 1'b0;
    cycle();
    bus.Start = 1'b1;
    cycle();
    bus.Start = 1'b0;
    repeat (10) cycle();

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
